// File: rtl/jpeg_ser_pkg.sv
// Shared types and constants for the JPEG byte serializer.
// Holds the FSM state encoding, the word-FIFO entry layout, the marker
// byte constants and the end-of-file padding helper.
package jpeg_ser_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        EMIT      = 3'd2,
        STUFF_CHK = 3'd3,
        STUFF     = 3'd4,
        END       = 3'd5,
        EOI_FF    = 3'd6,
        EOI_D9    = 3'd7
    } state_t;

    // One buffered word: last marks the end-of-file partial word, cnt is
    // its number of valid MSB-aligned bits (0 for ordinary full words).
    typedef struct packed {
        logic        last;
        logic [4:0]  cnt;
        logic [31:0] data;
    } fifo_entry_t;

    localparam logic [7:0] MARKER_FF  = 8'hFF;
    localparam logic [7:0] EOI_CODE   = 8'hD9;
    localparam logic [7:0] STUFF_BYTE = 8'h00;

    // Fill every bit below the cnt valid MSBs with 1s, as JPEG requires
    // for the final partial byte.
    function automatic logic [31:0] pad_final(input logic [31:0] data,
                                              input logic [4:0]  cnt);
        return data | (32'hFFFF_FFFF >> cnt);
    endfunction

endpackage

// File: rtl/jpeg_word_fifo.sv
// Synchronous word FIFO for the JPEG byte serializer.
// Pointers carry an extra wrap bit to tell full from empty. A push while
// full is accepted only when a pop frees the head slot in the same cycle;
// otherwise it is silently dropped (the caller flags overflow).
module jpeg_word_fifo
    import jpeg_ser_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  fifo_entry_t wr_entry,
    input  logic        pop,
    output fifo_entry_t rd_entry,
    output logic        full,
    output logic        empty
);

    fifo_entry_t mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign rd_entry = mem[rd_ptr[AW-1:0]];

    // Pointer update; reset empties the FIFO without touching storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Entry storage write.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_entry;
    end

endmodule

// File: rtl/jpeg_byte_serializer.sv
// JPEG byte serializer: buffers 32-bit stuffed words from the encoder and
// streams them MSB-first as bytes over a valid/ready handshake. The final
// partial word is padded with 1s, a 0x00 stuff byte follows a padded 0xFF,
// and with JPEG_EOI_INSERT_EN defined the EOI marker FF D9 closes the frame.
module jpeg_byte_serializer
    import jpeg_ser_pkg::*;
#(
    parameter  int FIFO_DEPTH = 8,
    localparam int AW         = $clog2(FIFO_DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] JPEG_bitstream,
    input  logic        data_ready,
    input  logic        eof_data_partial_ready,
    input  logic [4:0]  end_of_file_bitstream_count,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        frame_done,
    output logic        overflow,
    output logic        protocol_err
);

    state_t      state;
    state_t      state_next;
    fifo_entry_t wr_entry;
    fifo_entry_t head;
    logic        push;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic        accept;

    // Current word: shreg holds the bytes still to follow byte_out.
    logic [31:0] shreg;
    logic [2:0]  nbytes;
    logic        cur_last;
    logic [2:0]  cur_tail_bits;

    // Head-entry decode used whenever a word is loaded.
    logic [31:0] head_padded;
    logic [2:0]  head_nbytes;
    logic        head_empty_frame;

    // FSM controls for the output datapath.
    logic        load_en;
    logic        shift_en;
    logic        drop_valid;
    logic        present_stuff;
    logic        present_ff;
    logic        present_d9;
    logic        done_set;

    assign accept = byte_valid && byte_ready;
    assign push   = data_ready || eof_data_partial_ready;

    // A full word wins over a simultaneous partial word.
    always_comb begin
        wr_entry.last = eof_data_partial_ready && !data_ready;
        wr_entry.cnt  = wr_entry.last ? end_of_file_bitstream_count : 5'd0;
        wr_entry.data = JPEG_bitstream;
    end

    jpeg_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .wr_entry (wr_entry),
        .pop      (pop),
        .rd_entry (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Decode the FIFO head into padded data and a byte count.
    always_comb begin
        head_empty_frame = head.last && (head.cnt == 5'd0);
        head_padded      = head.last ? pad_final(head.data, head.cnt) : head.data;
        head_nbytes      = head.last ? 3'(({1'b0, head.cnt} + 6'd7) >> 3) : 3'd4;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and datapath control. A word that ends while another is
    // queued is reloaded in the same cycle so consecutive words have no gap.
    always_comb begin
        state_next    = state;
        pop           = 1'b0;
        load_en       = 1'b0;
        shift_en      = 1'b0;
        drop_valid    = 1'b0;
        present_stuff = 1'b0;
        present_ff    = 1'b0;
        present_d9    = 1'b0;
        done_set      = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) state_next = LOAD;
            end
            LOAD: begin
                pop        = 1'b1;
                load_en    = 1'b1;
                state_next = head_empty_frame ? END : EMIT;
            end
            EMIT: begin
                if (accept) begin
                    if (nbytes > 3'd1) begin
                        shift_en = 1'b1;
                    end else if (cur_last) begin
                        drop_valid = 1'b1;
                        state_next = STUFF_CHK;
                    end else if (!fifo_empty) begin
                        pop        = 1'b1;
                        load_en    = 1'b1;
                        state_next = head_empty_frame ? END : EMIT;
                    end else begin
                        drop_valid = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            STUFF_CHK: begin
                if (cur_tail_bits != 3'd0 && byte_out == MARKER_FF) begin
                    present_stuff = 1'b1;
                    state_next    = STUFF;
                end else begin
                    state_next = END;
                end
            end
            STUFF: begin
                if (accept) begin
                    drop_valid = 1'b1;
                    state_next = END;
                end
            end
            END: begin
`ifdef JPEG_EOI_INSERT_EN
                present_ff = 1'b1;
                state_next = EOI_FF;
`else
                done_set   = 1'b1;
                state_next = IDLE;
`endif
            end
`ifdef JPEG_EOI_INSERT_EN
            EOI_FF: begin
                if (accept) begin
                    present_d9 = 1'b1;
                    state_next = EOI_D9;
                end
            end
            EOI_D9: begin
                if (accept) begin
                    drop_valid = 1'b1;
                    done_set   = 1'b1;
                    state_next = IDLE;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // Output byte register, word bookkeeping and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_valid    <= 1'b0;
            byte_out      <= 8'h00;
            frame_done    <= 1'b0;
            overflow      <= 1'b0;
            protocol_err  <= 1'b0;
            nbytes        <= 3'd0;
            cur_last      <= 1'b0;
            cur_tail_bits <= 3'd0;
        end else begin
            frame_done <= done_set;
            if (push && fifo_full && !pop)
                overflow <= 1'b1;
            if (data_ready && eof_data_partial_ready)
                protocol_err <= 1'b1;
            if (load_en) begin
                byte_valid    <= !head_empty_frame;
                if (!head_empty_frame) byte_out <= head_padded[31:24];
                nbytes        <= head_nbytes;
                cur_last      <= head.last;
                cur_tail_bits <= head.cnt[2:0];
            end else if (shift_en) begin
                byte_out <= shreg[31:24];
                nbytes   <= nbytes - 3'd1;
            end else if (present_stuff) begin
                byte_valid <= 1'b1;
                byte_out   <= STUFF_BYTE;
            end else if (present_ff) begin
                byte_valid <= 1'b1;
                byte_out   <= MARKER_FF;
            end else if (present_d9) begin
                byte_out   <= EOI_CODE;
            end else if (drop_valid) begin
                byte_valid <= 1'b0;
            end
        end
    end

    // Remaining-byte shift register; pure data, no reset needed.
    always_ff @(posedge clk) begin
        if (load_en)       shreg <= head_padded << 8;
        else if (shift_en) shreg <= shreg << 8;
    end

endmodule

// File: tb/tb_jpeg_byte_serializer.sv
// Directed testbench for jpeg_byte_serializer. Expected byte streams are
// written out by hand; the FF D9 trailer is added when JPEG_EOI_INSERT_EN
// is defined for the build.
module tb_jpeg_byte_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] JPEG_bitstream;
    logic        data_ready;
    logic        eof_data_partial_ready;
    logic [4:0]  end_of_file_bitstream_count;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        frame_done;
    logic        overflow;
    logic        protocol_err;

    int total = 0;
    int bad   = 0;

    logic [7:0] got[$];
    int         got_cyc[$];
    logic [7:0] exp_q[$];
    int         cyc      = 0;
    int         done_cnt = 0;

    always #5 clk = ~clk;

    jpeg_byte_serializer #(.FIFO_DEPTH(8)) dut (
        .clk                         (clk),
        .rst                         (rst),
        .JPEG_bitstream              (JPEG_bitstream),
        .data_ready                  (data_ready),
        .eof_data_partial_ready      (eof_data_partial_ready),
        .end_of_file_bitstream_count (end_of_file_bitstream_count),
        .byte_out                    (byte_out),
        .byte_valid                  (byte_valid),
        .byte_ready                  (byte_ready),
        .frame_done                  (frame_done),
        .overflow                    (overflow),
        .protocol_err                (protocol_err)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs only change 1 time unit after a rising edge, so values seen on
    // the falling edge are exactly what the next rising edge samples.
    always @(negedge clk) begin
        if (byte_valid === 1'b1 && byte_ready === 1'b1) begin
            got.push_back(byte_out);
            got_cyc.push_back(cyc);
        end
        if (frame_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        data_ready     = 1'b1;
        JPEG_bitstream = w;
        tick();
        data_ready     = 1'b0;
    endtask

    task automatic push_last(input logic [31:0] w, input logic [4:0] c);
        eof_data_partial_ready      = 1'b1;
        JPEG_bitstream              = w;
        end_of_file_bitstream_count = c;
        tick();
        eof_data_partial_ready      = 1'b0;
        end_of_file_bitstream_count = 5'd0;
    endtask

    task automatic add_eoi();
`ifdef JPEG_EOI_INSERT_EN
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hD9);
`endif
    endtask

    task automatic wait_done(input string tag, input int limit, input int start);
        int n = 0;
        while (done_cnt == start && n < limit) begin
            tick();
            n++;
        end
        chk({tag, "_done_seen"}, 32'(done_cnt > start), 32'd1);
        repeat (5) tick();
        chk({tag, "_done_once"}, 32'(done_cnt - start), 32'd1);
    endtask

    task automatic cmp_stream(input string tag);
        chk({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got.size())
                chk($sformatf("%s_b%0d", tag, i), {24'h0, got[i]}, {24'h0, exp_q[i]});
            else
                chk($sformatf("%s_b%0d", tag, i), 32'hDEAD_BEEF, {24'h0, exp_q[i]});
        end
    endtask

    initial begin
        int d0;
        logic stable;

        rst                         = 1'b1;
        JPEG_bitstream              = 32'h0;
        data_ready                  = 1'b0;
        eof_data_partial_ready      = 1'b0;
        end_of_file_bitstream_count = 5'd0;
        byte_ready                  = 1'b0;
        tick();
        tick();
        chk("rst_valid", {31'h0, byte_valid}, 32'd0);
        chk("rst_byte", {24'h0, byte_out}, 32'd0);
        chk("rst_done", {31'h0, frame_done}, 32'd0);
        chk("rst_ovf", {31'h0, overflow}, 32'd0);
        chk("rst_perr", {31'h0, protocol_err}, 32'd0);
        rst = 1'b0;
        tick();

        // Two full words then an empty partial word; first byte at N+2.
        got.delete(); got_cyc.delete();
        exp_q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        add_eoi();
        d0 = done_cnt;
        byte_ready = 1'b1;
        push_word(32'h1234_5678);
        push_word(32'h9ABC_DEF0);
        chk("t1_lat_n1", {31'h0, byte_valid}, 32'd0);
        push_last(32'h0000_0000, 5'd0);
        chk("t1_lat_n2_valid", {31'h0, byte_valid}, 32'd1);
        chk("t1_lat_n2_byte", {24'h0, byte_out}, 32'h12);
        wait_done("t1", 40, d0);
        cmp_stream("t1");
        chk("t1_no_bubble", (got_cyc.size() >= 8) ? 32'(got_cyc[7] - got_cyc[0]) : 32'hFFFF_FFFF, 32'd7);

        // Partial word of 3 bits: A0 padded to BF.
        got.delete(); got_cyc.delete();
        exp_q = '{8'hBF};
        add_eoi();
        d0 = done_cnt;
        push_last(32'hA000_0000, 5'd3);
        wait_done("t2", 40, d0);
        cmp_stream("t2");

        // Partial word of 7 bits padding to FF needs a stuff byte.
        got.delete(); got_cyc.delete();
        exp_q = '{8'hFF, 8'h00};
        add_eoi();
        d0 = done_cnt;
        push_last(32'hFE00_0000, 5'd7);
        wait_done("t3", 40, d0);
        cmp_stream("t3");

        // Downstream stall for 5 cycles on the second byte of a word.
        got.delete(); got_cyc.delete();
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        add_eoi();
        d0 = done_cnt;
        push_word(32'h1122_3344);
        tick();
        tick();
        tick();
        byte_ready = 1'b0;
        stable = 1'b1;
        repeat (5) begin
            tick();
            if (!(byte_valid === 1'b1 && byte_out === 8'h22)) stable = 1'b0;
        end
        chk("t4_stall_stable", {31'h0, stable}, 32'd1);
        chk("t4_stall_byte", {24'h0, byte_out}, 32'h22);
        byte_ready = 1'b1;
        push_last(32'h0, 5'd0);
        wait_done("t4", 40, d0);
        cmp_stream("t4");

        // One word held in the output stage plus 9 more: the 9th is dropped.
        got.delete(); got_cyc.delete();
        exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        for (int i = 1; i <= 8; i++) repeat (4) exp_q.push_back(8'(i));
        add_eoi();
        d0 = done_cnt;
        byte_ready = 1'b0;
        push_word(32'hA0A1_A2A3);
        for (int i = 1; i <= 9; i++) push_word(32'h0101_0101 * 32'(i));
        chk("t5_overflow", {31'h0, overflow}, 32'd1);
        chk("t5_hold_valid", {31'h0, byte_valid}, 32'd1);
        chk("t5_hold_byte", {24'h0, byte_out}, 32'hA0);
        byte_ready = 1'b1;
        repeat (12) tick();
        push_last(32'h0, 5'd0);
        wait_done("t5", 80, d0);
        cmp_stream("t5");

        // Full and partial strobes together: full word wins, no frame end.
        got.delete(); got_cyc.delete();
        exp_q = '{8'h55, 8'h66, 8'h77, 8'h88};
        d0 = done_cnt;
        data_ready                  = 1'b1;
        eof_data_partial_ready      = 1'b1;
        end_of_file_bitstream_count = 5'd5;
        JPEG_bitstream              = 32'h5566_7788;
        tick();
        data_ready                  = 1'b0;
        eof_data_partial_ready      = 1'b0;
        end_of_file_bitstream_count = 5'd0;
        chk("t6_perr", {31'h0, protocol_err}, 32'd1);
        repeat (20) tick();
        chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
        cmp_stream("t6");

        // Reset while emitting discards everything; next frame is clean.
        byte_ready = 1'b0;
        push_word(32'hC1C2_C3C4);
        push_word(32'hB1B2_B3B4);
        tick();
        chk("t7_pre_valid", {31'h0, byte_valid}, 32'd1);
        d0 = done_cnt;
        rst = 1'b1;
        tick();
        chk("t7_rst_valid", {31'h0, byte_valid}, 32'd0);
        chk("t7_rst_byte", {24'h0, byte_out}, 32'd0);
        chk("t7_rst_done", {31'h0, frame_done}, 32'd0);
        chk("t7_rst_ovf", {31'h0, overflow}, 32'd0);
        chk("t7_rst_perr", {31'h0, protocol_err}, 32'd0);
        rst = 1'b0;
        byte_ready = 1'b1;
        got.delete(); got_cyc.delete();
        repeat (6) tick();
        chk("t7_fifo_empty", 32'(got.size()), 32'd0);
        chk("t7_idle_valid", {31'h0, byte_valid}, 32'd0);
        chk("t7_no_done", 32'(done_cnt - d0), 32'd0);
        exp_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        add_eoi();
        push_word(32'hDEAD_BEEF);
        push_last(32'h0, 5'd0);
        wait_done("t7", 40, d0);
        cmp_stream("t7");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
